// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : Instruction prefetch queue with credit-limited IROM requests and
//            redirect flush that discards responses still in flight.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 32,
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [ADDR_W-1:0]          mem_req_addr,
    input  logic                       mem_rsp_valid,
    input  logic [DATA_W-1:0]          mem_rsp_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [DATA_W-1:0]          out_inst,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_out_w = $clog2(MAX_OUT + 1);
    localparam int c_sum_w = ((c_cnt_w > c_out_w) ? c_cnt_w : c_out_w) + 1;
    localparam logic [ADDR_W-1:0] c_step = ADDR_W'(DATA_W / 8);

    logic                 r_run;
    logic [ADDR_W-1:0]    r_fetch_pc;
    logic [ADDR_W-1:0]    r_rsp_pc;
    logic [c_out_w-1:0]   r_outstanding;
    logic [c_out_w-1:0]   r_drop;
    logic [c_cnt_w-1:0]   r_count;
    logic [c_ptr_w-1:0]   r_head;
    logic [c_ptr_w-1:0]   r_tail;
    logic [ADDR_W-1:0]    r_pc_mem   [DEPTH];
    logic [DATA_W-1:0]    r_inst_mem [DEPTH];

    logic [c_sum_w-1:0]   w_sum;
    logic                 w_issue;
    logic                 w_push;
    logic                 w_pop;

    // Queue slots plus in-flight requests form the credit pool, so a response
    // always has a free slot when it lands.
    assign w_sum         = c_sum_w'(r_count) + c_sum_w'(r_outstanding);
    assign mem_req_valid = r_run
                         && (w_sum < c_sum_w'(DEPTH))
                         && (r_outstanding < c_out_w'(MAX_OUT))
                         && !redirect_valid;
    assign mem_req_addr  = r_fetch_pc;
    assign w_issue       = mem_req_valid && mem_req_ready;
    assign w_push        = mem_rsp_valid && (r_drop == '0) && !redirect_valid;
    assign w_pop         = out_valid && out_ready && !redirect_valid;

    assign out_valid = (r_count != '0);
    assign out_pc    = r_pc_mem[r_head];
    assign out_inst  = r_inst_mem[r_head];
    assign count     = r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run         <= 1'b0;
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_count       <= '0;
            r_head        <= '0;
            r_tail        <= '0;
        end else begin
            r_run         <= 1'b1;
            r_outstanding <= r_outstanding + c_out_w'(w_issue) - c_out_w'(mem_rsp_valid);
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc;
                r_rsp_pc   <= redirect_pc;
                // Drop-marked responses are a subset of the outstanding ones,
                // so after a flush every in-flight response is to be dropped.
                r_drop     <= r_outstanding - c_out_w'(mem_rsp_valid);
                r_count    <= '0;
                r_head     <= '0;
                r_tail     <= '0;
            end else begin
                if (w_issue) begin
                    r_fetch_pc <= r_fetch_pc + c_step;
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + c_step;
                    r_tail   <= r_tail + c_ptr_w'(1);
                end
                if (mem_rsp_valid && (r_drop != '0)) begin
                    r_drop <= r_drop - c_out_w'(1);
                end
                if (w_pop) begin
                    r_head <= r_head + c_ptr_w'(1);
                end
                r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_tail]   <= r_rsp_pc;
            r_inst_mem[r_tail] <= mem_rsp_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Brief    : Directed self-checking bench for fetch_queue with a 1-cycle IROM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [2:0]  count;

    int          n_vec = 0;
    int          n_err = 0;
    bit          rsp_en;
    logic [31:0] pend[$];
    logic [31:0] req_log[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_inst[$];

    fetch_queue dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: IROM answers last cycle's accepted request with ~addr.
    task automatic tick();
        if (rsp_en && pend.size() > 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = ~pend.pop_front();
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
        end
        #1;
        if (mem_req_valid && mem_req_ready) begin
            pend.push_back(mem_req_addr);
            req_log.push_back(mem_req_addr);
        end
        if (out_valid && out_ready) begin
            pop_pc.push_back(out_pc);
            pop_inst.push_back(out_inst);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_logs();
        req_log.delete();
        pop_pc.delete();
        pop_inst.delete();
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_req_ready  = 1'b0;
        out_ready      = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = '0;
        rsp_en         = 1'b0;
        pend.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        tick();
        clear_logs();
    endtask

    // Four accepted requests, with the IROM pipelined so two are in flight.
    task automatic lead_in();
        mem_req_ready = 1'b1;
        out_ready     = 1'b1;
        rsp_en        = 1'b1;
        repeat (3) tick();
        rsp_en = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; mem_req_ready = 1'b0;
        out_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; rsp_en = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_vec++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_req_valid: got %b expected 0", mem_req_valid); end
        n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", count); end
        @(negedge clk);
        rst = 1'b1;
        tick();
        n_vec++; if (mem_req_valid !== 1'b1) begin n_err++; $display("FAIL first_req_valid: got %b expected 1", mem_req_valid); end
        n_vec++; if (mem_req_addr !== 32'h0) begin n_err++; $display("FAIL first_req_addr: got %h expected 00000000", mem_req_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] exp;
        clear_logs();
        mem_req_ready = 1'b1;
        out_ready     = 1'b1;
        rsp_en        = 1'b1;
        repeat (12) tick();
        n_vec++; if (req_log.size() !== 12) begin n_err++; $display("FAIL stream_req_n: got %0d expected 12", req_log.size()); end
        n_vec++; if (pop_pc.size() !== 10) begin n_err++; $display("FAIL stream_pop_n: got %0d expected 10", pop_pc.size()); end
        for (int i = 0; i < 10; i++) begin
            exp = 32'(4 * i);
            n_vec++; if (req_log[i] !== exp) begin n_err++; $display("FAIL stream_req[%0d]: got %h expected %h", i, req_log[i], exp); end
            n_vec++; if (pop_pc[i] !== exp) begin n_err++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, pop_pc[i], exp); end
            n_vec++; if (pop_inst[i] !== ~exp) begin n_err++; $display("FAIL stream_inst[%0d]: got %h expected %h", i, pop_inst[i], ~exp); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        mem_req_ready = 1'b1;
        out_ready     = 1'b0;
        rsp_en        = 1'b1;
        repeat (10) tick();
        n_vec++; if (req_log.size() !== 4) begin n_err++; $display("FAIL stall_req_n: got %0d expected 4", req_log.size()); end
        n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL stall_count: got %0d expected 4", count); end
        n_vec++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL stall_req_valid: got %b expected 0", mem_req_valid); end
        n_vec++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL stall_head: got %h expected 00000000", out_pc); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        repeat (6) tick();
        n_vec++; if (req_log.size() !== 5) begin n_err++; $display("FAIL refill_req_n: got %0d expected 5", req_log.size()); end
        n_vec++; if (req_log[4] !== 32'h10) begin n_err++; $display("FAIL refill_addr: got %h expected 00000010", req_log[4]); end
        n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL refill_count: got %0d expected 4", count); end
        n_vec++; if (out_pc !== 32'h4) begin n_err++; $display("FAIL refill_head: got %h expected 00000004", out_pc); end
    endtask

    task automatic test_redirect();
        logic [31:0] exp;
        do_reset();
        lead_in();
        n_vec++; if (req_log[3] !== 32'hC) begin n_err++; $display("FAIL redir_setup: got %h expected 0000000c", req_log[3]); end
        clear_logs();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL redir_count: got %0d expected 0", count); end
        n_vec++; if (req_log.size() !== 0) begin n_err++; $display("FAIL redir_no_req: got %0d expected 0", req_log.size()); end
        rsp_en = 1'b1;
        repeat (6) tick();
        n_vec++; if (req_log[0] !== 32'h100) begin n_err++; $display("FAIL redir_req0: got %h expected 00000100", req_log[0]); end
        n_vec++; if (pop_pc.size() !== 3) begin n_err++; $display("FAIL redir_pop_n: got %0d expected 3", pop_pc.size()); end
        for (int i = 0; i < 3; i++) begin
            exp = 32'h100 + 32'(4 * i);
            n_vec++; if (pop_pc[i] !== exp) begin n_err++; $display("FAIL redir_pc[%0d]: got %h expected %h", i, pop_pc[i], exp); end
            n_vec++; if (pop_inst[i] !== ~exp) begin n_err++; $display("FAIL redir_inst[%0d]: got %h expected %h", i, pop_inst[i], ~exp); end
        end
    endtask

    task automatic test_redirect_rsp();
        logic [31:0] exp;
        do_reset();
        lead_in();
        clear_logs();
        rsp_en         = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        repeat (6) tick();
        n_vec++; if (pop_pc.size() !== 4) begin n_err++; $display("FAIL rrsp_pop_n: got %0d expected 4", pop_pc.size()); end
        for (int i = 0; i < 4; i++) begin
            exp = 32'h200 + 32'(4 * i);
            n_vec++; if (pop_pc[i] !== exp) begin n_err++; $display("FAIL rrsp_pc[%0d]: got %h expected %h", i, pop_pc[i], exp); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        do_reset();
        lead_in();
        clear_logs();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        tick();
        rsp_en      = 1'b1;
        redirect_pc = 32'h400;
        tick();
        redirect_valid = 1'b0;
        repeat (6) tick();
        n_vec++; if (req_log[0] !== 32'h400) begin n_err++; $display("FAIL b2b_req0: got %h expected 00000400", req_log[0]); end
        n_vec++; if (pop_pc.size() !== 4) begin n_err++; $display("FAIL b2b_pop_n: got %0d expected 4", pop_pc.size()); end
        for (int i = 0; i < 4; i++) begin
            exp = 32'h400 + 32'(4 * i);
            n_vec++; if (pop_pc[i] !== exp) begin n_err++; $display("FAIL b2b_pc[%0d]: got %h expected %h", i, pop_pc[i], exp); end
        end
    endtask

    task automatic test_ready_stall_wrap();
        logic [31:0] exp;
        do_reset();
        out_ready = 1'b1;
        rsp_en    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++; if (mem_req_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid[%0d]: got %b expected 1", i, mem_req_valid); end
            n_vec++; if (mem_req_addr !== 32'h0) begin n_err++; $display("FAIL hold_addr[%0d]: got %h expected 00000000", i, mem_req_addr); end
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        #1;
        n_vec++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL redir_cycle_valid: got %b expected 0", mem_req_valid); end
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++; if (mem_req_addr !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL hold2_addr[%0d]: got %h expected fffffff8", i, mem_req_addr); end
        end
        clear_logs();
        mem_req_ready = 1'b1;
        repeat (8) tick();
        for (int i = 0; i < 4; i++) begin
            exp = 32'hFFFF_FFF8 + 32'(4 * i);
            n_vec++; if (req_log[i] !== exp) begin n_err++; $display("FAIL wrap_req[%0d]: got %h expected %h", i, req_log[i], exp); end
            n_vec++; if (pop_pc[i] !== exp) begin n_err++; $display("FAIL wrap_pc[%0d]: got %h expected %h", i, pop_pc[i], exp); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_req_ready = 1'b1;
        out_ready     = 1'b0;
        rsp_en        = 1'b1;
        repeat (4) tick();
        n_vec++; if (count !== 3'd3) begin n_err++; $display("FAIL mid_count_pre: got %0d expected 3", count); end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_valid_pre: got %b expected 1", out_valid); end
        #2;
        rst           = 1'b0;
        mem_rsp_valid = 1'b0;
        rsp_en        = 1'b0;
        pend.delete();
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_async_valid: got %b expected 0", out_valid); end
        n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL mid_async_count: got %0d expected 0", count); end
        n_vec++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL mid_async_req: got %b expected 0", mem_req_valid); end
        mem_req_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        n_vec++; if (mem_req_valid !== 1'b1) begin n_err++; $display("FAIL mid_restart_valid: got %b expected 1", mem_req_valid); end
        n_vec++; if (mem_req_addr !== 32'h0) begin n_err++; $display("FAIL mid_restart_addr: got %h expected 00000000", mem_req_addr); end
        clear_logs();
        mem_req_ready = 1'b1;
        out_ready     = 1'b1;
        rsp_en        = 1'b1;
        repeat (5) tick();
        n_vec++; if (pop_pc[0] !== 32'h0) begin n_err++; $display("FAIL mid_pc0: got %h expected 00000000", pop_pc[0]); end
        n_vec++; if (pop_pc[1] !== 32'h4) begin n_err++; $display("FAIL mid_pc1: got %h expected 00000004", pop_pc[1]); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_rsp();
        test_back_to_back();
        test_ready_stall_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
